regfile_scoreboard: RTL and testbench

//   Parametrised integer register file for the pipelined core: 2 async read ports, 1 write port,
//   x0 hard-wired to zero, optional same-cycle write->read bypass, per-register pending-write

---
 rtl/regfile_scoreboard_if.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 110 +++++++++++
 tb/tb_regfile_scoreboard.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bundle of the register file with scoreboard.
// master drives addresses, writeback, issue and debug select.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            ready;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            stall;
  logic [AW:0]     pend_cnt;
  logic [AW-1:0]   dbg_sel;
  logic [XLEN-1:0] dbg_data;

  modport master (
    input  ready, rs1_data, rs2_data,
    input  rs1_busy, rs2_busy, stall,
    input  pend_cnt, dbg_data,
    output rs1_addr, rs2_addr,
    output wr_en, wr_addr, wr_data,
    output iss_en, iss_rd, dbg_sel
  );

  modport slave (
    output ready, rs1_data, rs2_data,
    output rs1_busy, rs2_busy, stall,
    output pend_cnt, dbg_data,
    input  rs1_addr, rs2_addr,
    input  wr_en, wr_addr, wr_data,
    input  iss_en, iss_rd, dbg_sel
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file: 2R/1W, x0 = 0, optional write bypass,
// pending-write scoreboard with stall, sweep clear after reset.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]     pcnt;
  logic            rdy;
  logic [XLEN-1:0] dbg;

  logic run;
  logic set_v, clr_v;
  logic inc, dec;
  logic byp1, byp2;
  logic busy1, busy2;

  assign run = (state == RUN);

  always_comb begin
    set_v = run && bus.iss_en
          && (bus.iss_rd != '0);
    clr_v = run && bus.wr_en
          && (bus.wr_addr != '0);
    pend_nxt = pend;
    if (clr_v) pend_nxt[bus.wr_addr] = 1'b0;
    // set wins: the newer producer is outstanding
    if (set_v) pend_nxt[bus.iss_rd] = 1'b1;
    inc = set_v && !pend[bus.iss_rd];
    dec = clr_v && pend[bus.wr_addr]
        && !(set_v
             && bus.iss_rd == bus.wr_addr);
  end

  always_comb begin
    byp1 = BYPASS && bus.wr_en
         && (bus.wr_addr == bus.rs1_addr);
    byp2 = BYPASS && bus.wr_en
         && (bus.wr_addr == bus.rs2_addr);
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (run && bus.rs1_addr != '0)
      bus.rs1_data = byp1 ? bus.wr_data
                          : regs[bus.rs1_addr];
    if (run && bus.rs2_addr != '0)
      bus.rs2_data = byp2 ? bus.wr_data
                          : regs[bus.rs2_addr];
    busy1 = run && pend[bus.rs1_addr] && !byp1;
    busy2 = run && pend[bus.rs2_addr] && !byp2;
  end

  assign bus.rs1_busy = busy1;
  assign bus.rs2_busy = busy2;
  assign bus.stall    = busy1 | busy2 | ~rdy;
  assign bus.ready    = rdy;
  assign bus.pend_cnt = pcnt;
  assign bus.dbg_data = dbg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      pend  <= '0;
      pcnt  <= '0;
      rdy   <= 1'b0;
      dbg   <= '0;
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NREGS - 1)) begin
            state <= RUN;
            rdy   <= 1'b1;
          end
        end
        RUN: begin
          pend <= pend_nxt;
          if (inc && !dec)
            pcnt <= pcnt + 1'b1;
          else if (dec && !inc)
            pcnt <= pcnt - 1'b1;
          dbg <= (bus.dbg_sel == '0) ? '0
               : regs[bus.dbg_sel];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        regs[cnt] <= '0;
      else if (clr_v)
        regs[bus.wr_addr] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: BYPASS=1 and BYPASS=0
// instances share stimulus; a monitor pops expectations per cycle.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bnb ();

  assign bnb.rs1_addr = bus.rs1_addr;
  assign bnb.rs2_addr = bus.rs2_addr;
  assign bnb.wr_en    = bus.wr_en;
  assign bnb.wr_addr  = bus.wr_addr;
  assign bnb.wr_data  = bus.wr_data;
  assign bnb.iss_en   = bus.iss_en;
  assign bnb.iss_rd   = bus.iss_rd;
  assign bnb.dbg_sel  = bus.dbg_sel;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b1)
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b0)
  ) dut_nb (.clk(clk), .rst(rst), .bus(bnb.slave));

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  string names [14] = '{
    "rs1_data", "rs2_data", "rs1_busy", "rs2_busy",
    "stall", "pend_cnt", "dbg_data", "ready",
    "nb_rs1_data", "nb_rs2_data", "nb_rs1_busy",
    "nb_rs2_busy", "nb_stall", "nb_pend_cnt"
  };

  function automatic logic [31:0] probe(int s);
    case (s)
      0:  return bus.rs1_data;
      1:  return bus.rs2_data;
      2:  return 32'(bus.rs1_busy);
      3:  return 32'(bus.rs2_busy);
      4:  return 32'(bus.stall);
      5:  return 32'(bus.pend_cnt);
      6:  return bus.dbg_data;
      7:  return 32'(bus.ready);
      8:  return bnb.rs1_data;
      9:  return bnb.rs2_data;
      10: return 32'(bnb.rs1_busy);
      11: return 32'(bnb.rs2_busy);
      12: return 32'(bnb.stall);
      13: return 32'(bnb.pend_cnt);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: everything tagged with the current cycle is compared
  initial begin
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        got = probe(e.sig);
        checks++;
        if (e.cyc != cyc || got !== e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h",
                   names[e.sig], cyc, got, e.exp);
        end
      end
    end
  end

  // reference model
  logic [31:0] m_regs [NREGS];
  bit          m_pend [NREGS];
  int          m_init;

  function automatic int pend_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++)
      if (m_pend[i]) n++;
    return n;
  endfunction

  task automatic push(int c, int s, logic [31:0] v);
    exp_t x;
    x.cyc = c;
    x.sig = s;
    x.exp = v;
    q.push_back(x);
  endtask

  task automatic step(
    bit r, int a1, int a2,
    bit we, int wa, logic [31:0] wd,
    bit ie, int ir, int ds
  );
    logic [31:0] e1, e2, n1, n2, dv;
    bit b1, b2, k1, k2, p1, p2;
    rst          = r;
    bus.rs1_addr = AW'(a1);
    bus.rs2_addr = AW'(a2);
    bus.wr_en    = we;
    bus.wr_addr  = AW'(wa);
    bus.wr_data  = wd;
    bus.iss_en   = ie;
    bus.iss_rd   = AW'(ir);
    bus.dbg_sel  = AW'(ds);
    if (r) begin
      m_init = NREGS;
      for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
      push(cyc + 1, 5, 0);
      push(cyc + 1, 13, 0);
      push(cyc + 1, 6, 0);
      push(cyc + 1, 7, 0);
    end else if (m_init > 0) begin
      for (int s = 0; s < 4; s++) push(cyc, s, 0);
      for (int s = 8; s < 12; s++) push(cyc, s, 0);
      push(cyc, 4, 1);
      push(cyc, 12, 1);
      m_init--;
      if (m_init == 0)
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
      push(cyc + 1, 7, 32'(m_init == 0));
      push(cyc + 1, 5, 0);
      push(cyc + 1, 13, 0);
    end else begin
      k1 = we && wa == a1;
      k2 = we && wa == a2;
      n1 = (a1 == 0) ? 32'h0 : m_regs[a1];
      n2 = (a2 == 0) ? 32'h0 : m_regs[a2];
      e1 = (a1 != 0 && k1) ? wd : n1;
      e2 = (a2 != 0 && k2) ? wd : n2;
      p1 = m_pend[a1];
      p2 = m_pend[a2];
      b1 = p1 && !k1;
      b2 = p2 && !k2;
      push(cyc, 0, e1);
      push(cyc, 1, e2);
      push(cyc, 2, 32'(b1));
      push(cyc, 3, 32'(b2));
      push(cyc, 4, 32'(b1 | b2));
      push(cyc, 8, n1);
      push(cyc, 9, n2);
      push(cyc, 10, 32'(p1));
      push(cyc, 11, 32'(p2));
      push(cyc, 12, 32'(p1 | p2));
      dv = (ds == 0) ? 32'h0 : m_regs[ds];
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 0;
      end
      if (ie && ir != 0) m_pend[ir] = 1;
      push(cyc + 1, 5, 32'(pend_count()));
      push(cyc + 1, 13, 32'(pend_count()));
      push(cyc + 1, 6, dv);
      push(cyc + 1, 7, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_init_step();
    step(0, $urandom_range(0, 31), $urandom_range(0, 31),
         1'($urandom), $urandom_range(0, 31), $urandom,
         1'($urandom), $urandom_range(0, 31),
         $urandom_range(0, 31));
  endtask

  initial begin
    int a1, a2, wa, ir;
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = 0;
      m_pend[i] = 0;
    end
    m_init = NREGS;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NREGS; i++) rand_init_step();

    // same-cycle bypass, then registered value
    step(0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    step(0, 5, 5, 0, 0, 0, 0, 0, 5);
    // x0 write and issue are dropped
    step(0, 0, 0, 1, 0, 32'h1234, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // issue x7, read busy, write clears with bypass
    step(0, 0, 0, 0, 0, 0, 1, 7, 0);
    step(0, 0, 7, 0, 0, 0, 0, 0, 0);
    step(0, 7, 7, 1, 7, 32'h55, 0, 0, 7);
    step(0, 7, 7, 0, 0, 0, 0, 0, 7);
    // issue and write x9 together while pending
    step(0, 0, 0, 0, 0, 0, 1, 9, 0);
    step(0, 9, 0, 1, 9, 32'hA, 1, 9, 9);
    step(0, 9, 9, 0, 0, 0, 0, 0, 9);

    for (int n = 0; n < 400; n++) begin
      a1 = $urandom_range(0, 31);
      a2 = $urandom_range(0, 31);
      wa = ($urandom_range(0, 3) == 0) ? a1
         : $urandom_range(0, 31);
      ir = ($urandom_range(0, 4) == 0) ? wa
         : $urandom_range(0, 31);
      step(0, a1, a2, 1'($urandom_range(0, 2) != 0),
           wa, $urandom, 1'($urandom_range(0, 1)),
           ir, $urandom_range(0, 31));
    end

    // reset again and abort the sweep at counter 10
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) rand_init_step();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NREGS; i++) rand_init_step();
    step(0, 3, 9, 0, 0, 0, 0, 0, 3);
    step(0, 7, 5, 0, 0, 0, 0, 0, 9);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
